// File: rtl/branch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// branch_pc_ctrl
//
// Purpose
//   Consumer side of the ID-stage branch compare result. Turns the comparator
//   output (cmpout) plus J/JR decode into the next fetch address. Owns the PC
//   register, the fetch request towards instruction memory, and a deferred
//   redirect that is parked while the pipeline is stalled.
//
// Handshake
//   pc/pc_req form a valid/ready pair with if_ready: a fetch is accepted in a
//   cycle where pc_req & if_ready are both high and the hazard unit is not
//   holding IF/ID (stall low). pc only changes on an accepted fetch, and pc is
//   held stable while pc_req is high and the fetch has not been accepted.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous reset, active low
//   id_pc      in   32  PC of the instruction currently in ID
//   br_valid   in   1   ID holds a conditional branch
//   cmpout     in   1   branch-taken result from the comparator
//   br_imm     in   16  branch offset field
//   j_valid    in   1   ID holds J/JAL
//   j_index    in   26  J instr_index field
//   jr_valid   in   1   ID holds JR/JALR
//   jr_target  in   32  forwarded register value for JR
//   stall      in   1   hazard-unit hold of IF/ID
//   if_ready   in   1   imem accepts pc this cycle
//   pc         out  32  fetch address
//   pc_req     out  1   fetch request valid
//   redirect   out  1   1-cycle pulse: pc was loaded from a control target
//   exc        out  1   1-cycle pulse: misaligned target trapped
//   state_dbg  out  2   FSM state (0 BOOT, 1 RUN, 2 PEND) for observation
//
// Configuration
//   MISALIGN_TRAP_EN  when defined, a target with [1:0] != 0 loads EXC_VEC and
//                     raises exc together with redirect. When undefined, the
//                     low two target bits are forced to zero and exc stays 0.
// -----------------------------------------------------------------------------
module branch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] id_pc,
   input  logic        br_valid,
   input  logic        cmpout,
   input  logic [15:0] br_imm,
   input  logic        j_valid,
   input  logic [25:0] j_index,
   input  logic        jr_valid,
   input  logic [31:0] jr_target,
   input  logic        stall,
   input  logic        if_ready,
   output logic [31:0] pc,
   output logic        pc_req,
   output logic        redirect,
   output logic        exc,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Control decode
   logic        adv;
   logic        take;

   // Target computation
   logic [31:0] id_pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] sel_tgt;
   logic [31:0] apply_src;
   logic [31:0] load_pc;
   logic        load_exc;

   // Pending target parked while a taken control transfer waits for adv
   logic [31:0] pend_tgt;

   // FSM outputs steering the datapath registers
   logic        do_seq;
   logic        do_redir;
   logic        do_capture;

   // adv is derived from state rather than pc_req so the output process has
   // no combinational feedback through pc_req.
   assign adv  = (state != BOOT) & if_ready & ~stall;
   assign take = jr_valid | j_valid | (br_valid & cmpout);

   assign id_pc_plus4 = id_pc + 32'd4;
   assign br_tgt      = id_pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
   assign j_tgt       = {id_pc_plus4[31:28], j_index, 2'b00};

   // Priority jr > j > br. br_tgt is only meaningful when take is set.
   always_comb begin
      sel_tgt = br_tgt;
      if (j_valid) begin
         sel_tgt = j_tgt;
      end
      if (jr_valid) begin
         sel_tgt = jr_target;
      end
   end

   // The target that lands on pc: the live selection in RUN, the parked one in
   // PEND. pend_tgt keeps the raw value so the alignment check happens at the
   // moment the target is applied, exactly as for a live target.
   assign apply_src = (state == PEND) ? pend_tgt : sel_tgt;

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      load_exc = (apply_src[1:0] != 2'b00);
      load_pc  = load_exc ? EXC_VEC : apply_src;
   end
`else
   logic unused_cfg;

   always_comb begin
      load_exc = 1'b0;
      load_pc  = {apply_src[31:2], 2'b00};
   end

   // Trap vector and low target bits have no consumer in this build.
   assign unused_cfg = ^{EXC_VEC, apply_src[1:0]};
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT: begin
            state_nxt = RUN;
         end
         RUN: begin
            if (!adv && take) begin
               state_nxt = PEND;
            end
         end
         PEND: begin
            // ID still holds the same transfer, so new take inputs are ignored.
            if (adv) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_req     = 1'b0;
      do_seq     = 1'b0;
      do_redir   = 1'b0;
      do_capture = 1'b0;
      case (state)
         BOOT: begin
            pc_req = 1'b0;
         end
         RUN: begin
            pc_req = 1'b1;
            if (adv && take) begin
               do_redir = 1'b1;
            end else if (adv) begin
               do_seq = 1'b1;
            end else if (take) begin
               do_capture = 1'b1;
            end
         end
         PEND: begin
            pc_req = 1'b1;
            if (adv) begin
               do_redir = 1'b1;
            end
         end
         default: begin
            pc_req = 1'b0;
         end
      endcase
   end

   assign state_dbg = state;

   // ---------------------------------------------------------------------------
   // Datapath registers. redirect/exc are registered so they line up with the
   // cycle in which the new pc is presented to instruction memory.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         pend_tgt <= 32'd0;
         redirect <= 1'b0;
         exc      <= 1'b0;
      end else begin
         redirect <= do_redir;
         exc      <= do_redir & load_exc;
         if (do_redir) begin
            pc <= load_pc;
         end else if (do_seq) begin
            // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 0.
            pc <= pc + 32'd4;
         end
         if (do_capture) begin
            pend_tgt <= sel_tgt;
         end
      end
   end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_pc_ctrl
//
// Directed bench for branch_pc_ctrl. Each accepted fetch (pc_req & if_ready &
// ~stall) is compared against a queue of hand-computed fetch records
// {exc, redirect, pc}; the driver pushes the expected record for the cycle it
// is driving, and a separate monitor pops on the falling edge. A few
// cycle-level checks (reset values, held pc, FSM state) are made directly.
// -----------------------------------------------------------------------------
module tb_branch_pc_ctrl;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_PEND = 2'd2;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] id_pc;
   logic        br_valid;
   logic        cmpout;
   logic [15:0] br_imm;
   logic        j_valid;
   logic [25:0] j_index;
   logic        jr_valid;
   logic [31:0] jr_target;
   logic        stall;
   logic        if_ready;
   logic [31:0] pc;
   logic        pc_req;
   logic        redirect;
   logic        exc;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   branch_pc_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .id_pc     (id_pc),
      .br_valid  (br_valid),
      .cmpout    (cmpout),
      .br_imm    (br_imm),
      .j_valid   (j_valid),
      .j_index   (j_index),
      .jr_valid  (jr_valid),
      .jr_target (jr_target),
      .stall     (stall),
      .if_ready  (if_ready),
      .pc        (pc),
      .pc_req    (pc_req),
      .redirect  (redirect),
      .exc       (exc),
      .state_dbg (state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [33:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Monitor: one record per accepted fetch.
   initial begin
      logic [33:0] want;
      forever begin
         @(negedge clk);
         if (rst_n && pc_req && if_ready && !stall) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL fetch_unexpected: got pc %h expected no fetch", pc);
            end else begin
               want = exp_q.pop_front();
               check("fetch {exc,redirect,pc}", {exc, redirect, pc}, want);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [31:0] p, input logic r, input logic e);
      exp_q.push_back({e, r, p});
   endtask

   task automatic clear_id();
      id_pc     = 32'd0;
      br_valid  = 1'b0;
      cmpout    = 1'b0;
      br_imm    = 16'd0;
      j_valid   = 1'b0;
      j_index   = 26'd0;
      jr_valid  = 1'b0;
      jr_target = 32'd0;
   endtask

   task automatic drive_br(input logic [31:0] ipc, input logic [15:0] imm, input logic c);
      clear_id();
      id_pc    = ipc;
      br_valid = 1'b1;
      br_imm   = imm;
      cmpout   = c;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst_n    = 1'b0;
      stall    = 1'b0;
      if_ready = 1'b1;
      clear_id();

      // Reset state
      repeat (3) tick();
      check("reset_pc",       {2'b0, pc},            {2'b0, 32'h0000_3000});
      check("reset_pc_req",   {33'b0, pc_req},       34'd0);
      check("reset_redirect", {33'b0, redirect},     34'd0);
      check("reset_exc",      {33'b0, exc},          34'd0);
      check("reset_state",    {32'b0, state_dbg},    {32'b0, S_BOOT});

      // 1: release, BOOT for one cycle then sequential fetch
      rst_n = 1'b1;
      #1;
      check("boot_pc_req", {33'b0, pc_req}, 34'd0);
      tick();
      check("run_pc_req", {33'b0, pc_req}, 34'd1);
      push(32'h3000, 1'b0, 1'b0);
      tick(); push(32'h3004, 1'b0, 1'b0);
      tick(); push(32'h3008, 1'b0, 1'b0);

      // 2a: taken backward branch, target 0x3008 - 4 = 0x3004
      tick(); drive_br(32'h3004, 16'hFFFF, 1'b1); push(32'h300C, 1'b0, 1'b0);
      tick(); clear_id(); push(32'h3004, 1'b1, 1'b0);
      // 2b: same branch not taken -> sequential, no redirect
      tick(); drive_br(32'h3004, 16'hFFFF, 1'b0); push(32'h3008, 1'b0, 1'b0);
      tick(); clear_id(); push(32'h300C, 1'b0, 1'b0);

      // 3: J from 0x3010, index 0xC40 -> 0x0000_3100
      j_valid = 1'b1; id_pc = 32'h3010; j_index = 26'h0000C40;
      tick(); clear_id(); push(32'h3100, 1'b1, 1'b0);
      tick(); push(32'h3104, 1'b0, 1'b0);

      // 4: taken branch to 0x3040 (0x3034 + 3*4) under a 2-cycle stall
      tick(); drive_br(32'h3030, 16'h0003, 1'b1); stall = 1'b1;
      tick();
      check("pend_pc_held",  {2'b0, pc},         {2'b0, 32'h3108});
      check("pend_state",    {32'b0, state_dbg}, {32'b0, S_PEND});
      check("pend_no_redir", {33'b0, redirect},  34'd0);
      tick(); stall = 1'b0; push(32'h3108, 1'b0, 1'b0);
      tick(); clear_id(); push(32'h3040, 1'b1, 1'b0);
      check("pend_back_run", {32'b0, state_dbg}, {32'b0, S_RUN});
      tick(); push(32'h3044, 1'b0, 1'b0);
      // imem back-pressure alone holds pc
      tick(); if_ready = 1'b0;
      tick(); if_ready = 1'b1;
      check("ifready_hold", {2'b0, pc}, {2'b0, 32'h3048});
      push(32'h3048, 1'b0, 1'b0);

      // 5: JR to misaligned 0x3002 beats a taken branch
      tick(); drive_br(32'h3000, 16'h0010, 1'b1);
      jr_valid = 1'b1; jr_target = 32'h3002;
      push(32'h304C, 1'b0, 1'b0);
      tick(); clear_id();
`ifdef MISALIGN_TRAP_EN
      push(32'h4180, 1'b1, 1'b1);
      tick(); push(32'h4184, 1'b0, 1'b0);
      tick(); push(32'h4188, 1'b0, 1'b0);
`else
      push(32'h3000, 1'b1, 1'b0);
      tick(); push(32'h3004, 1'b0, 1'b0);
      tick(); push(32'h3008, 1'b0, 1'b0);
`endif
      // J beats a taken branch: J from 0x3010, index 0xC80 -> 0x3200
      drive_br(32'h3010, 16'h0001, 1'b1);
      j_valid = 1'b1; j_index = 26'h0000C80;
      tick(); clear_id(); push(32'h3200, 1'b1, 1'b0);

      // 6: JR to 0xFFFF_FFFC, then sequential wrap to 0
      tick(); jr_valid = 1'b1; jr_target = 32'hFFFF_FFFC; push(32'h3204, 1'b0, 1'b0);
      tick(); clear_id(); push(32'hFFFF_FFFC, 1'b1, 1'b0);
      tick(); push(32'h0000_0000, 1'b0, 1'b0);

      // Reset while PEND discards the pending target
      tick(); drive_br(32'h3030, 16'h0003, 1'b1); stall = 1'b1;
      tick();
      check("pend2_state", {32'b0, state_dbg}, {32'b0, S_PEND});
      rst_n = 1'b0;
      #1;
      check("rst_pend_pc",     {2'b0, pc},         {2'b0, 32'h0000_3000});
      check("rst_pend_pc_req", {33'b0, pc_req},    34'd0);
      check("rst_pend_state",  {32'b0, state_dbg}, {32'b0, S_BOOT});
      clear_id(); stall = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick(); push(32'h3000, 1'b0, 1'b0);
      tick(); push(32'h3004, 1'b0, 1'b0);

      // Drain: no further fetches accepted, queue must be empty
      tick(); if_ready = 1'b0;
      tick(); tick();
      check("queue_drained", 34'(exp_q.size()), 34'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog: the directed sequence is short; anything longer is a hang.
   initial begin
      #20000;
      n_checks++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
